// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program sequencer: opcode/state encodings and control-word field positions.
package prog_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_EXEC = 3'd0,
        OP_JMP  = 3'd1,
        OP_BZ   = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_HALT = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } seq_state_t;

    // Opcode occupies the top OP_W bits of the control word; target sits at bit 0.
    localparam int OP_W       = 3;
    localparam int TARGET_LSB = 0;

    // Unassigned codes 5 and 6 execute as plain words.
    function automatic op_t decode_op(input logic [OP_W-1:0] raw);
        case (raw)
            3'd1:    return OP_JMP;
            3'd2:    return OP_BZ;
            3'd3:    return OP_CALL;
            3'd4:    return OP_RET;
            3'd7:    return OP_HALT;
            default: return OP_EXEC;
        endcase
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO of Depth entries; push/pop take effect on the clock edge, top-of-stack read is combinational.
// Push when full and pop when empty are ignored; clr_i empties the stack synchronously.
module ret_stack #(
    parameter int Depth = 2,
    parameter int Width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] push_dat_i,
    output logic [Width-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int SpW  = $clog2(Depth + 1);
    localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [SpW-1:0]   sp_q, sp_d;
    logic [Width-1:0] mem_q [Depth];
    logic [IdxW-1:0]  wr_idx, rd_idx;

    assign full_o  = (sp_q == SpW'(Depth));
    assign empty_o = (sp_q == '0);
    assign wr_idx  = IdxW'(sp_q);
    assign rd_idx  = IdxW'(sp_q - 1'b1);
    assign pop_dat_o = empty_o ? '0 : mem_q[rd_idx];

    always_comb begin
        sp_d = sp_q;
        if (clr_i)
            sp_d = '0;
        else if (push_i && !full_o)
            sp_d = sp_q + 1'b1;
        else if (pop_i && !empty_o)
            sp_d = sp_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
            for (int i = 0; i < Depth; i++)
                mem_q[i] <= '0;
        end else begin
            sp_q <= sp_d;
            if (!clr_i && push_i && !full_o)
                mem_q[wr_idx] <= push_dat_i;
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Program counter and fetch controller: issues one registered control word per unstalled cycle, resolving jumps, branches, call/return and halt.
// Flow changes insert one bubble; stall freezes pc/ctrlOut/stack and drops ctrlValid.
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int Psize = 4,
    parameter int Csize = 11,
    parameter int Depth = 2
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             start,
    input  logic             stall,
    input  logic             zeroFlag,
    input  logic [Csize-1:0] controlWord,
    output logic [Psize-1:0] addr,
    output logic [Csize-1:0] ctrlOut,
    output logic             ctrlValid,
    output logic             halted,
    output logic             fault
);

    localparam int OP_LSB = Csize - OP_W;

    seq_state_t       state_q, state_d;
    logic [Psize-1:0] pc_q, pc_d;
    logic [Csize-1:0] ctrl_q, ctrl_d;
    logic             valid_q, valid_d;
    logic             fault_q, fault_d;

    op_t              op;
    logic [Psize-1:0] target, pc_inc;
    logic             stk_push, stk_pop, stk_clr, stk_full, stk_empty;
    logic [Psize-1:0] stk_top;

    assign op     = decode_op(controlWord[Csize-1:OP_LSB]);
    assign target = controlWord[TARGET_LSB +: Psize];
    assign pc_inc = pc_q + 1'b1;

    ret_stack #(
        .Depth (Depth),
        .Width (Psize)
    ) u_ret_stack (
        .clk        (clk),
        .rst_n      (nReset),
        .clr_i      (stk_clr),
        .push_i     (stk_push),
        .pop_i      (stk_pop),
        .push_dat_i (pc_inc),
        .pop_dat_o  (stk_top),
        .full_o     (stk_full),
        .empty_o    (stk_empty)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ctrl_d   = ctrl_q;
        valid_d  = 1'b0;
        fault_d  = fault_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_clr  = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED: begin
                // start beats stall here; stall only matters once running
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    stk_clr = 1'b1;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    case (op)
                        OP_JMP:  pc_d = target;
                        OP_BZ:   pc_d = zeroFlag ? target : pc_inc;
                        OP_CALL: begin
                            if (stk_full) begin
                                fault_d = 1'b1;
                                state_d = S_HALTED;
                            end else begin
                                stk_push = 1'b1;
                                pc_d     = target;
                            end
                        end
                        OP_RET: begin
                            if (stk_empty) begin
                                fault_d = 1'b1;
                                state_d = S_HALTED;
                            end else begin
                                stk_pop = 1'b1;
                                pc_d    = stk_top;
                            end
                        end
                        OP_HALT: state_d = S_HALTED;
                        default: begin
                            ctrl_d  = controlWord;
                            valid_d = 1'b1;
                            pc_d    = pc_inc;
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr      = pc_q;
        ctrlOut   = ctrl_q;
        ctrlValid = valid_q;
        halted    = (state_q == S_HALTED);
        fault     = fault_q;
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed vector table, hand-written corner sequences, randomized run against a queue-based model.
module tb_prog_sequencer;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        zeroFlag = 1'b0;
    logic [10:0] controlWord;
    logic [3:0]  addr;
    logic [10:0] ctrlOut;
    logic        ctrlValid, halted, fault;

    logic [10:0] mem [16];
    int checks = 0;
    int errors = 0;

    assign controlWord = mem[addr];

    always #5 clk = ~clk;

    prog_sequencer #(.Psize(4), .Csize(11), .Depth(2)) dut (
        .clk(clk), .nReset(nReset), .start(start), .stall(stall), .zeroFlag(zeroFlag),
        .controlWord(controlWord), .addr(addr), .ctrlOut(ctrlOut), .ctrlValid(ctrlValid),
        .halted(halted), .fault(fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one tick after an edge; releases reset away from the clock edge.
    task automatic do_reset();
        nReset = 1'b0;
        start  = 1'b0;
        stall  = 1'b0;
        #3;
        nReset = 1'b1;
        step();
    endtask

    task automatic load_exec();
        for (int i = 0; i < 16; i++)
            mem[i] = {3'b000, 4'(i), 4'(15 - i)};
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Reference model: plain arithmetic and a queue for the return stack.
    int m_state;  // 0 idle, 1 run, 2 halted
    int m_pc;
    logic [10:0] m_ctrl;
    logic m_valid, m_fault;
    int m_stk[$];

    task automatic model_reset();
        m_state = 0; m_pc = 0; m_ctrl = '0; m_valid = 1'b0; m_fault = 1'b0;
        m_stk.delete();
    endtask

    task automatic model_step(input bit st, input bit sl, input bit zf);
        logic [10:0] w;
        int op, tgt;
        w   = mem[m_pc];
        op  = int'(w[10:8]);
        tgt = int'(w[3:0]);
        m_valid = 1'b0;
        if (m_state != 1) begin
            if (st) begin
                m_state = 1; m_pc = 0; m_stk.delete();
            end
        end else if (!sl) begin
            if (op == 1) m_pc = tgt;
            else if (op == 2) m_pc = zf ? tgt : (m_pc + 1) % 16;
            else if (op == 3) begin
                if (m_stk.size() == 2) begin m_fault = 1'b1; m_state = 2; end
                else begin m_stk.push_back((m_pc + 1) % 16); m_pc = tgt; end
            end else if (op == 4) begin
                if (m_stk.size() == 0) begin m_fault = 1'b1; m_state = 2; end
                else m_pc = m_stk.pop_back();
            end else if (op == 7) m_state = 2;
            else begin
                m_ctrl = w; m_valid = 1'b1; m_pc = (m_pc + 1) % 16;
            end
        end
    endtask

    typedef struct packed {
        logic [10:0]     w2;
        logic            zf;
        logic [4:0][3:0] ea;   // expected addr, element i = sample i after start
        logic [4:0]      ev;   // expected ctrlValid, bit i = sample i
        logic            eh;
        logic            ef;
    } vec_t;

    vec_t vecs [8];
    logic [10:0] held;
    bit st, sl, zf;

    initial begin
        vecs[0] = '{11'h0AB, 1'b0, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0},  5'b11110, 1'b0, 1'b0};
        vecs[1] = '{11'h109, 1'b0, {4'd10, 4'd9, 4'd2, 4'd1, 4'd0}, 5'b10110, 1'b0, 1'b0};
        vecs[2] = '{11'h207, 1'b1, {4'd8, 4'd7, 4'd2, 4'd1, 4'd0},  5'b10110, 1'b0, 1'b0};
        vecs[3] = '{11'h207, 1'b0, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0},  5'b10110, 1'b0, 1'b0};
        vecs[4] = '{11'h700, 1'b0, {4'd2, 4'd2, 4'd2, 4'd1, 4'd0},  5'b00110, 1'b1, 1'b0};
        vecs[5] = '{11'h308, 1'b0, {4'd9, 4'd8, 4'd2, 4'd1, 4'd0},  5'b10110, 1'b0, 1'b0};
        vecs[6] = '{11'h400, 1'b0, {4'd2, 4'd2, 4'd2, 4'd1, 4'd0},  5'b00110, 1'b1, 1'b1};
        vecs[7] = '{11'h5AB, 1'b0, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0},  5'b11110, 1'b0, 1'b0};

        load_exec();
        #1;
        check("reset_outputs", {14'b0, addr, ctrlOut, ctrlValid, halted, fault}, 32'd0);
        do_reset();
        step();
        check("idle_hold", {27'b0, addr, ctrlValid}, 32'd0);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            load_exec();
            mem[2]   = vecs[v].w2;
            zeroFlag = vecs[v].zf;
            pulse_start();
            for (int i = 0; i < 5; i++) begin
                if (i > 0) step();
                check($sformatf("vec%0d_addr%0d", v, i), 32'(addr), 32'(vecs[v].ea[i]));
                check($sformatf("vec%0d_valid%0d", v, i), 32'(ctrlValid), 32'(vecs[v].ev[i]));
            end
            check($sformatf("vec%0d_halted", v), 32'(halted), 32'(vecs[v].eh));
            check($sformatf("vec%0d_fault", v), 32'(fault), 32'(vecs[v].ef));
        end
        zeroFlag = 1'b0;

        // Straight-line run wraps 15 -> 0 without fault
        do_reset();
        load_exec();
        pulse_start();
        for (int i = 0; i < 17; i++) begin
            if (i > 0) step();
            check($sformatf("wrap_addr%0d", i), 32'(addr), 32'(i % 16));
            check($sformatf("wrap_valid%0d", i), 32'(ctrlValid), 32'(i > 0));
        end
        check("wrap_fault", 32'(fault), 32'd0);

        // Call then return resumes after the call site
        do_reset();
        load_exec();
        mem[1] = 11'h308;
        mem[8] = 11'h400;
        pulse_start();
        step(); step();
        check("call_addr", 32'(addr), 32'd8);
        step();
        check("ret_addr", 32'(addr), 32'd2);
        step();
        check("ret_next", {27'b0, addr, ctrlValid}, {27'b0, 4'd3, 1'b1});

        // Third nested call overflows a two-deep stack
        do_reset();
        load_exec();
        mem[0] = 11'h304; mem[4] = 11'h308; mem[8] = 11'h30C;
        pulse_start();
        step(); step(); step();
        check("overflow", {26'b0, addr, ctrlValid, halted, fault}, {26'b0, 4'd8, 1'b0, 1'b1, 1'b1});
        step();
        check("overflow_sticky", {26'b0, addr, ctrlValid, halted, fault}, {26'b0, 4'd8, 1'b0, 1'b1, 1'b1});
        do_reset();
        check("fault_cleared", {30'b0, halted, fault}, 32'd0);

        // Stall for three cycles at addr 5
        load_exec();
        pulse_start();
        for (int i = 0; i < 5; i++) step();
        check("pre_stall", 32'(addr), 32'd5);
        held = ctrlOut;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall%0d", i), {16'b0, addr, ctrlOut, ctrlValid}, {16'b0, 4'd5, held, 1'b0});
        end
        stall = 1'b0;
        step();
        check("stall_resume", {16'b0, addr, ctrlOut, ctrlValid}, {16'b0, 4'd6, mem[5], 1'b1});

        // Asynchronous reset between edges
        #2 nReset = 1'b0;
        #1 check("async_reset", {14'b0, addr, ctrlOut, ctrlValid, halted, fault}, 32'd0);
        #2 nReset = 1'b1;
        step();

        // Halt, restart, and start ignored while running
        load_exec();
        mem[4] = 11'h700;
        pulse_start();
        for (int i = 0; i < 5; i++) step();
        check("halt_state", {27'b0, addr, halted}, {27'b0, 4'd4, 1'b1});
        step();
        check("halt_hold", {26'b0, addr, ctrlValid, halted, fault}, {26'b0, 4'd4, 1'b0, 1'b1, 1'b0});
        stall = 1'b1;
        pulse_start();
        stall = 1'b0;
        check("restart", {27'b0, addr, halted}, {27'b0, 4'd0, 1'b0});
        step();
        pulse_start();
        check("start_in_run", 32'(addr), 32'd2);

        // Randomized run against the model
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            model_reset();
            for (int i = 0; i < 16; i++) begin
                int r;
                r = $urandom_range(0, 15);
                mem[i] = {(r < 9) ? 3'($urandom_range(0, 6) == 5 ? 5 : 0) : 3'(r == 9 ? 1 : r == 10 ? 2 : r == 11 ? 3 : r == 12 ? 4 : r == 13 ? 7 : 6),
                          8'($urandom)};
            end
            for (int c = 0; c < 250; c++) begin
                st = ($urandom_range(0, 19) == 0);
                sl = ($urandom_range(0, 3) == 0);
                zf = 1'($urandom);
                start = st; stall = sl; zeroFlag = zf;
                model_step(st, sl, zf);
                step();
                check($sformatf("rand_ep%0d_c%0d", ep, c),
                      {14'b0, addr, ctrlOut, ctrlValid, halted, fault},
                      {14'b0, 4'(m_pc), m_ctrl, m_valid, (m_state == 2), m_fault});
            end
        end
        start = 1'b0; stall = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Program-counter and fetch controller for the program memory: drives the Psize-bit address, registers the returned Csize-bit control word into a control register for the datapath, and resolves jumps, conditional branches, call/return and halt.
- Sits between the program memory and the datapath decode. The program memory read is combinational (zero latency), so one control word issues per unstalled cycle.

Parameters:
- Psize, 4, program address width; memory depth 2^Psize
- Csize, 11, control word width; must be >= Psize+3
- Depth, 2, return-stack entries

Ports:
- clk  in  1  system clock, rising edge
- nReset  in  1  asynchronous, active-low reset
- start  in  1  pulse; leaves IDLE/HALTED and begins execution at address 0
- stall  in  1  datapath back-pressure; freezes the sequencer
- zeroFlag  in  1  datapath condition flag, sampled in the cycle the BZ word is fetched
- controlWord  in  Csize  word read from program memory at addr
- addr  out  Psize  program memory address (equals pc)
- ctrlOut  out  Csize  registered control word to the datapath
- ctrlValid  out  1  ctrlOut is an executable word this cycle
- halted  out  1  sequencer is in HALTED
- fault  out  1  sticky stack overflow/underflow indication

Behaviour:
- Reset (async, nReset=0): state=IDLE, pc=0, ctrlOut=0, ctrlValid=0, halted=0, fault=0, sp=0.
- Control word fields:
  - op = controlWord[Csize-1:Csize-3].
  - target = controlWord[Psize-1:0].
  - Opcodes: EXEC=0, JMP=1, BZ=2, CALL=3, RET=4, HALT=7. Codes 5 and 6 are treated as EXEC.
- States: IDLE, RUN, HALTED.
- IDLE:
  - addr=pc=0, ctrlValid=0.
  - start=1 -> RUN next cycle, with pc=0.
- RUN, stall=0, per cycle:
  - EXEC: ctrlOut<=controlWord, ctrlValid<=1, pc<=pc+1.
  - JMP: pc<=target, ctrlValid<=0 (bubble).
  - BZ:
    - zeroFlag=1 -> pc<=target.
    - zeroFlag=0 -> pc<=pc+1.
    - ctrlValid<=0 in both cases.
  - CALL:
    - stack[sp]<=pc+1, sp<=sp+1, pc<=target, ctrlValid<=0.
    - sp==Depth -> fault<=1, state<=HALTED.
  - RET:
    - pc<=stack[sp-1], sp<=sp-1, ctrlValid<=0.
    - sp==0 -> fault<=1, state<=HALTED.
  - HALT: state<=HALTED, ctrlValid<=0, pc unchanged.
- RUN, stall=1:
  - pc, ctrlOut, sp and stack are held.
  - ctrlValid<=0.
  - zeroFlag is ignored.
- Address arithmetic: pc+1 wraps modulo 2^Psize (address 15 -> 0 at default). Wrap is not a fault.
- HALTED:
  - halted=1, ctrlValid=0, addr holds the last pc.
  - start=1 -> pc<=0, sp<=0, halted<=0, state<=RUN. fault is cleared only by reset.
- start while in RUN is ignored.
- stall and start together in IDLE/HALTED: start wins; stall applies from the next cycle.
- Reset asserted mid-operation returns every register to its reset value immediately, independent of clk.

Decomposition:
- Shared package (definitions):
  - op_t enum: EXEC, JMP, BZ, CALL, RET, HALT.
  - seq_state_t enum: IDLE, RUN, HALTED.
  - Field-position constants for op and target.
- One sub-module, ret_stack:
  - Depth x Psize LIFO.
  - Ports: push, pop, data in/out, full, empty; async active-low reset.

Test Plan:
- Reset, then start; memory of 16 EXEC words -> addr steps 0..15 then wraps to 0, ctrlValid=1 every cycle after the first, fault=0.
- mem[3]=JMP 9 -> addr sequence 0,1,2,3,9,10, one ctrlValid=0 bubble after word 3.
- mem[2]=BZ 7: zeroFlag=1 -> addr goes 2 to 7; zeroFlag=0 -> addr goes 2 to 3; both cases produce one bubble.
- mem[1]=CALL 8, mem[8]=RET -> addr 0,1,8,1? No: addr 0,1,8,2; three nested CALLs with Depth=2 -> fault=1 and halted=1 on the third.
- stall held high for 3 cycles at addr 5 -> addr stays 5, ctrlValid=0, ctrlOut unchanged; resumes at 6.
- mem[4]=HALT -> halted=1 with addr held at 4; start pulse -> RUN from addr 0. nReset pulsed low mid-run -> all outputs 0 asynchronously.
